// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the write port of a single synchronous FIFO between NUM_REQ
//   producers. Producers are granted round-robin. Each grant accepts at most
//   BURST_LEN words, so no producer can hold the FIFO indefinitely.
//
//   Ports
//     clk, reset     clock; synchronous active-high reset
//     req_valid      per-requester data valid
//     req_data       packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_ready      per-requester accept strobe (one-hot or zero)
//     fifo_wr        FIFO write strobe
//     fifo_data      FIFO write data (don't-care when fifo_wr=0)
//     fifo_full      FIFO full flag
//     grant_id       currently (or most recently) granted requester
//     busy           high while a grant is held
//
//   Optional build macro FIFO_WR_ARBITER_STATS_EN adds:
//     stall_cnt      16-bit saturating count of granted cycles stalled by full
//     drop_grant_cnt 8-bit saturating count of grants released because the
//                    owner dropped valid before completing a full burst
module fifo_wr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int BURST_LEN  = 4,
    localparam int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BW         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    input  logic                          fifo_full,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    output logic [15:0]                   stall_cnt,
    output logic [7:0]                    drop_grant_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

    logic            g_valid;
    logic [DATA_WIDTH-1:0] g_data;
    logic [GW-1:0]   pick;

    // View of the granted requester only. Non-granted valids never reach
    // an output combinationally.
    always_comb begin
        g_valid = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == GW'(i)) begin
                g_valid = req_valid[i];
                g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Round-robin search starting at rr_ptr. Walking offsets from the far
    // end down lets the nearest asserted requester win without a break.
    always_comb begin
        pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx]) pick = GW'(idx);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        logic release_g;
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        release_g  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_id_d = pick;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (!g_valid) begin
                    release_g = 1'b1;
                end else if (!fifo_full) begin
                    if (beat_cnt_q == BW'(BURST_LEN - 1)) release_g = 1'b1;
                    else beat_cnt_d = beat_cnt_q + 1'b1;
                end
                // full with valid: hold grant and beat count, no timeout
            end
            default: state_d = IDLE;
        endcase
        if (release_g) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        end
    end

    // Outputs
    always_comb begin
        logic xfer;
        xfer      = (state_q == GRANT) && g_valid && !fifo_full;
        fifo_wr   = xfer;
        fifo_data = g_data;
        busy      = (state_q == GRANT);
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = xfer && (grant_id_q == GW'(i));
    end

    assign grant_id = grant_id_q;

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [7:0]  drop_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else if (state_q == GRANT) begin
            if (g_valid && fifo_full && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            // Dropping valid always ends a grant short of a full burst.
            if (!g_valid && drop_cnt_q != 8'hFF)
                drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign stall_cnt      = stall_cnt_q;
    assign drop_grant_cnt = drop_cnt_q;
`else
    // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              fifo_wr;
    logic [DW-1:0]     fifo_data;
    logic              fifo_full;
    logic [1:0]        grant_id;
    logic              busy;
`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [15:0]       stall_cnt;
    logic [7:0]        drop_grant_cnt;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_wr(fifo_wr), .fifo_data(fifo_data), .fifo_full(fifo_full),
        .grant_id(grant_id), .busy(busy)
`ifdef FIFO_WR_ARBITER_STATS_EN
        , .stall_cnt(stall_cnt), .drop_grant_cnt(drop_grant_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int busy; int gid; int wr; int rdy; int stall; int drop;
    } exp_t;

    exp_t cyc_q[$];     // per-cycle expected control outputs
    int   wr_q[$];      // expected FIFO write data, in order

    // Producers: pending words, whether they want to offer, and whether an
    // offered word is still awaiting acceptance (must stay asserted).
    int pend[N][$];
    bit want[N];
    bit hold[N];
    bit vld[N];

    // Reference model: who owns the FIFO, words left in its burst, where
    // the next search starts, and the statistics.
    int owner, left, rr, gid, stalls, drops;
    int wr_by[N];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares outputs mid-cycle, consuming a data expectation
    // whenever the DUT strobes a write.
    always @(negedge clk) begin
        exp_t e;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            chk("busy", busy, e.busy);
            chk("grant_id", grant_id, e.gid);
            chk("fifo_wr", fifo_wr, e.wr);
            chk("req_ready", req_ready, e.rdy);
`ifdef FIFO_WR_ARBITER_STATS_EN
            chk("stall_cnt", stall_cnt, e.stall);
            chk("drop_grant_cnt", drop_grant_cnt, e.drop);
`endif
            if (fifo_wr === 1'b1) begin
                if (wr_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL fifo_data: unexpected write of %0h at %0t", fifo_data, $time);
                end else begin
                    chk("fifo_data", fifo_data, wr_q.pop_front());
                end
            end
        end
    end

    task automatic release_owner();
        rr    = (owner + 1) % N;
        owner = -1;
    endtask

    // One clock cycle: drive producers, predict outputs, advance model.
    task automatic cycle();
        bit   x;
        bit   found;
        exp_t e;
        int   w;
        for (int i = 0; i < N; i++) begin
            vld[i] = hold[i] || (pend[i].size() > 0 && want[i]);
            req_valid[i] = vld[i];
            w = vld[i] ? pend[i][0] : int'($urandom);
            req_data[i*DW +: DW] = w[DW-1:0];
        end
        x = (owner >= 0) && vld[owner] && !fifo_full;
        e.busy  = (owner >= 0);
        e.gid   = gid;
        e.wr    = x;
        e.rdy   = x ? (1 << owner) : 0;
        e.stall = stalls;
        e.drop  = drops;
        cyc_q.push_back(e);
        if (x) wr_q.push_back(pend[owner][0] & 8'hFF);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) hold[i] = vld[i] && !(x && i == owner);
        if (x) begin
            void'(pend[owner].pop_front());
            wr_by[owner]++;
        end
        if (reset) begin
            owner = -1; rr = 0; gid = 0; stalls = 0; drops = 0;
        end else if (owner < 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && vld[(rr + k) % N]) begin
                    found = 1;
                    owner = (rr + k) % N;
                end
            end
            if (found) begin
                gid  = owner;
                left = BL;
            end
        end else if (!vld[owner]) begin
            if (drops < 255) drops++;
            release_owner();
        end else if (x) begin
            left--;
            if (left == 0) release_owner();
        end else begin
            if (stalls < 65535) stalls++;
        end
    endtask

    task automatic drain(int max_cycles);
        for (int c = 0; c < max_cycles; c++) begin
            bit empty;
            empty = (owner < 0);
            for (int i = 0; i < N; i++) if (pend[i].size() > 0 || hold[i]) empty = 0;
            if (empty) break;
            cycle();
        end
    endtask

    initial begin
        int base;
        int stall_left;
        bit done;
        reset     = 1'b1;
        fifo_full = 1'b0;
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            want[i] = 0; hold[i] = 0; vld[i] = 0; wr_by[i] = 0;
        end
        @(posedge clk);
        #1;
        owner = -1; left = 0; rr = 0; gid = 0; stalls = 0; drops = 0;

        // Reset held, then idle with no requests
        repeat (2) cycle();
        reset = 1'b0;
        repeat (10) cycle();

        // Single requester 2, six words: two bursts then release on drop
        for (int k = 0; k < 6; k++) pend[2].push_back(8'hA0 + k);
        want[2] = 1;
        drain(40);
        repeat (2) cycle();

        // All requesters continuously valid
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 8; k++) pend[i].push_back(8'h10 * i + k);
            want[i] = 1;
        end
        drain(120);
        repeat (2) cycle();

        // Requester 1 stalled by full for 5 cycles after its 2nd word
        for (int k = 0; k < 6; k++) pend[1].push_back(8'hB0 + k);
        base = wr_by[1];
        stall_left = 5;
        for (int c = 0; c < 60; c++) begin
            fifo_full = (wr_by[1] - base >= 2) && (stall_left > 0);
            if (fifo_full) stall_left--;
            cycle();
        end
        fifo_full = 1'b0;
        drain(20);

        // Reset during the 3rd beat of requester 0, then regrant
        for (int k = 0; k < 6; k++) pend[0].push_back(8'hC0 + k);
        base = wr_by[0];
        done = 0;
        for (int c = 0; c < 40; c++) begin
            reset = (wr_by[0] - base == 2) && !done;
            if (reset) done = 1;
            cycle();
        end
        reset = 1'b0;
        drain(20);

        // Randomized traffic, backpressure and occasional reset
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i].size() == 0 && $urandom_range(3, 0) == 0)
                    repeat ($urandom_range(6, 1)) pend[i].push_back($urandom_range(255, 0));
                want[i] = ($urandom_range(2, 0) != 0);
            end
            fifo_full = ($urandom_range(3, 0) == 0);
            reset     = ($urandom_range(99, 0) == 0);
            cycle();
        end
        reset     = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) want[i] = 1;
        drain(200);
        repeat (2) cycle();

        @(negedge clk);
        #1;
        chk("leftover_writes", wr_q.size(), 0);
        chk("leftover_cycles", cyc_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
